hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Consumes decoded ID-stage control (rd, wen_rf, en_dmem, load_store) and EX redirect/MEM handshake inputs.
- Keeps its own shadow scoreboard of EX/MEM/WB destinations and generates stall, flush, forwarding selects and the data-memory wait freeze.

Parameters:
MEM_TIMEOUT, 16, max cycles MEM_WAIT holds before aborting the access (>=2)
CNT_W, 5, width of the timeout counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2  in  5  source register indices in ID
id_use_rs1, id_use_rs2  in  1  instruction reads rs1/rs2
id_rd  in  5  destination index in ID
id_wen_rf  in  1  ID instruction writes the register file
id_en_dmem  in  1  ID instruction accesses dmem
id_load_store  in  1  0=load, 1=store (valid when id_en_dmem)
ex_redirect  in  1  branch taken or jump resolved in EX this cycle
dmem_ready  in  1  dmem completes the access presented this cycle
stall_if, stall_id  out  1  hold PC / IF-ID register
bubble_ex  out  1  load NOP into ID/EX
flush_id  out  1  clear IF/ID
freeze  out  1  hold EX/MEM/WB pipeline registers
dmem_req  out  1  MEM stage has a live dmem access
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 MEM result, 10 WB result
mem_err  out  1  sticky: an access timed out

Behaviour:
- Shadow entries ex_q, mem_q, wb_q = {valid, rd, wen, is_mem, is_load, rs1, rs2}; ex_q carries rs1/rs2 when the corresponding use bit is set, else 0.
- Reset: all entries invalid, state RUN, counter 0, mem_err 0. All outputs 0 during reset and the cycle after.
- A hazard match requires valid & wen & rd!=0.
- FSM states RUN and MEM_WAIT.
- RUN, evaluated combinationally each cycle:
  - dmem_req = mem_q.valid & mem_q.is_mem.
  - If dmem_req & !dmem_ready: freeze = stall_if = stall_id = 1, no bubble/flush. Next state MEM_WAIT, counter <= 1.
  - Else if ex_redirect: flush_id = 1, bubble_ex = 1, no stall. Redirect outranks load-use.
  - Else if load-use (ex_q.valid & is_load & wen & rd!=0 & id_valid & ((id_use_rs1 & rs1==rd) | (id_use_rs2 & rs2==rd))): stall_if = stall_id = bubble_ex = 1 for exactly one cycle.
- MEM_WAIT:
  - freeze, stall_if and stall_id held at 1; ex_redirect ignored (the EX instruction is frozen).
  - dmem_ready: return to RUN; pipeline advances this cycle.
  - Else if counter == MEM_TIMEOUT-1: mem_err <= 1, access dropped, return to RUN, advance.
  - Else counter increments.
- Shadow advance (when freeze=0): wb_q <= mem_q; mem_q <= ex_q; ex_q <= invalid if bubble_ex or !id_valid, else ID fields.
- Forwarding (combinational, EX operands):
  - fwd_a = 01 if mem_q matches ex_q.rs1 & !mem_q.is_load; else 10 if wb_q matches; else 00. fwd_b same on rs2. MEM priority over WB.
  - x0 never forwards.
- Store data dependence is treated like any rs2 use. Stores (wen=0) never cause a load-use stall as producers.
- Reset mid-MEM_WAIT: immediate return to RUN, all in-flight shadows invalidated.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments every cycle stall_if=1.
  - flush_count increments every cycle flush_id=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package rv_pipe_pkg: stage_entry_t struct, fwd_sel_t enum (FWD_RF=0, FWD_MEM=1, FWD_WB=2), hz_state_t enum, OPC_LOAD/OPC_STORE constants shared with the control decoder.
- One natural sub-module, hazard_fwd_sel: pure combinational match/priority for one operand, instantiated twice (fwd_a, fwd_b).

Test Plan:
- lw x5 then add x6,x5,x1 back-to-back -> exactly one cycle stall_if=stall_id=bubble_ex=1; next cycle fwd_a=10.
- addi x3 then sub x4,x3,x3 -> no stall; fwd_a=fwd_b=01; with one instruction between -> both 10; rd=x0 -> 00.
- Load in MEM, dmem_ready low 3 cycles -> freeze=1 for 3 cycles, shadows unchanged, advance on 4th; mem_err stays 0.
- dmem_ready never asserted, MEM_TIMEOUT=16 -> freeze for 16 cycles, mem_err=1 sticky, pipeline resumes.
- ex_redirect in same cycle as load-use condition -> flush_id=1, bubble_ex=1, stall_if=0.
- rst asserted during MEM_WAIT -> next cycle state RUN, all outputs 0, prior rd no longer forwards.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared pipeline types for the RV32I 5-stage core.
// Shadow stage entries, forwarding selects, hazard FSM states.
package rv_pipe_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       is_mem;
    logic       is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } stage_entry_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hz_state_t;

  localparam logic OPC_LOAD  = 1'b0;
  localparam logic OPC_STORE = 1'b1;

  localparam stage_entry_t ENTRY_NONE = '0;

  // x0 is never a producer, so rs==0 can never match
  function automatic logic rd_hit(
    input stage_entry_t e,
    input logic [4:0]   rs
  );
    return e.valid & e.wen & (e.rd != 5'd0) & (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: EX operand bypass select for one source register.
// MEM result wins over WB; a load still in MEM cannot bypass.
module hazard_fwd_sel
  import rv_pipe_pkg::*;
(
  input  stage_entry_t mem_e,
  input  stage_entry_t wb_e,
  input  logic [4:0]   src,
  output fwd_sel_t     sel
);

  always_comb begin
    sel = FWD_RF;
    if (rd_hit(mem_e, src) && !mem_e.is_load) begin
      sel = FWD_MEM;
    end else if (rd_hit(wb_e, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward sequencer with dmem wait freeze.
// Define HAZARD_PERF_CNT_EN for stall_cycles/flush_count outputs.
module hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_wen_rf,
  input  logic       id_en_dmem,
  input  logic       id_load_store,
  input  logic       ex_redirect,
  input  logic       dmem_ready,
  output logic       stall_if,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       flush_id,
  output logic       freeze,
  output logic       dmem_req,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             live_q, live_d;
  stage_entry_t     ex_q, ex_d;
  stage_entry_t     mem_q, mem_d;
  stage_entry_t     wb_q, wb_d;
  stage_entry_t     id_e;

  logic     req, load_use;
  logic     frz, stl, bub, fls, drop;
  fwd_sel_t sel_a, sel_b;

  always_comb begin
    id_e         = ENTRY_NONE;
    id_e.valid   = 1'b1;
    id_e.rd      = id_rd;
    id_e.wen     = id_wen_rf;
    id_e.is_mem  = id_en_dmem;
    id_e.is_load = id_en_dmem & (id_load_store == OPC_LOAD);
    id_e.rs1     = id_use_rs1 ? id_rs1 : 5'd0;
    id_e.rs2     = id_use_rs2 ? id_rs2 : 5'd0;
  end

  assign req = mem_q.valid & mem_q.is_mem;

  assign load_use = ex_q.is_load & id_valid &
    ((id_use_rs1 & rd_hit(ex_q, id_rs1)) |
     (id_use_rs2 & rd_hit(ex_q, id_rs2)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    live_d  = 1'b1;
    frz     = 1'b0;
    stl     = 1'b0;
    bub     = 1'b0;
    fls     = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (req && !dmem_ready) begin
          frz     = 1'b1;
          stl     = 1'b1;
          state_d = ST_MEM_WAIT;
          cnt_d   = CNT_ONE;
        end else if (ex_redirect && live_q) begin
          fls = 1'b1;
          bub = 1'b1;
        end else if (load_use) begin
          stl = 1'b1;
          bub = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // IF/ID stays held, so the advancing cycle feeds EX a NOP
        stl = 1'b1;
        if (dmem_ready) begin
          bub     = 1'b1;
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          frz     = 1'b1;
          drop    = 1'b1;
          err_d   = 1'b1;
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          frz   = 1'b1;
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!frz) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = (bub || !id_valid) ? ENTRY_NONE : id_e;
    end else if (drop) begin
      mem_d = ENTRY_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
      ex_q    <= ENTRY_NONE;
      mem_q   <= ENTRY_NONE;
      wb_q    <= ENTRY_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      live_q  <= live_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  hazard_fwd_sel u_fwd_a (
    .mem_e (mem_q),
    .wb_e  (wb_q),
    .src   (ex_q.rs1),
    .sel   (sel_a)
  );

  hazard_fwd_sel u_fwd_b (
    .mem_e (mem_q),
    .wb_e  (wb_q),
    .src   (ex_q.rs2),
    .sel   (sel_b)
  );

  assign stall_if  = stl & ~rst;
  assign stall_id  = stl & ~rst;
  assign bubble_ex = bub & ~rst;
  assign flush_id  = fls & ~rst;
  assign freeze    = frz & ~rst;
  assign dmem_req  = req & ~rst;
  assign fwd_a     = rst ? FWD_RF : sel_a;
  assign fwd_b     = rst ? FWD_RF : sel_b;
  assign mem_err   = err_q & ~rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, stall_if};
    flush_count_d  = flush_count_q + {31'd0, flush_id};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl.
// Expected output vectors queued per cycle, popped by a monitor.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2;
  logic       id_wen_rf, id_en_dmem, id_load_store;
  logic       ex_redirect, dmem_ready;
  logic       stall_if, stall_id, bubble_ex, flush_id;
  logic       freeze, dmem_req, mem_err;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .id_rd         (id_rd),
    .id_wen_rf     (id_wen_rf),
    .id_en_dmem    (id_en_dmem),
    .id_load_store (id_load_store),
    .ex_redirect   (ex_redirect),
    .dmem_ready    (dmem_ready),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .bubble_ex     (bubble_ex),
    .flush_id      (flush_id),
    .freeze        (freeze),
    .dmem_req      (dmem_req),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .mem_err       (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [10:0] v;
  } sb_t;

  sb_t sb[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic chk(input string tag, input logic [10:0] got,
                     input logic [10:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // {mem_err, dmem_req, freeze, flush_id, bubble_ex, stall_id, stall_if, fwd_b, fwd_a}
  function automatic logic [10:0] ov(
    input logic st, input logic bub, input logic fl,
    input logic fz, input logic req, input logic err,
    input logic [1:0] fa, input logic [1:0] fb);
    return {err, req, fz, fl, bub, st, st, fb, fa};
  endfunction

  always @(negedge clk) begin
    sb_t e;
    #4;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, {mem_err, dmem_req, freeze, flush_id, bubble_ex,
                  stall_id, stall_if, fwd_b, fwd_a}, e.v);
    end
  end

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic exq(input string tag, input logic [10:0] v);
    sb_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic id_set(input logic v, input logic [4:0] rd,
                        input logic wen, input logic [4:0] r1,
                        input logic u1, input logic [4:0] r2,
                        input logic u2, input logic mem,
                        input logic st);
    id_valid      = v;
    id_rd         = rd;
    id_wen_rf     = wen;
    id_rs1        = r1;
    id_use_rs1    = u1;
    id_rs2        = r2;
    id_use_rs2    = u2;
    id_en_dmem    = mem;
    id_load_store = st;
  endtask

  task automatic id_off();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] r1,
                     input logic u1, input logic [4:0] r2,
                     input logic u2);
    id_set(1, rd, 1, r1, u1, r2, u2, 0, 0);
  endtask

  task automatic lw(input logic [4:0] rd, input logic [4:0] r1);
    id_set(1, rd, 1, r1, 1, 0, 0, 1, 0);
  endtask

  localparam logic [10:0] Z = 11'd0;

  initial begin
    rst = 1'b1;
    ex_redirect = 1'b1;
    dmem_ready = 1'b1;
    lw(5'd5, 5'd1);

    // reset and the cycle after: all outputs quiet despite redirect
    nx(); exq("rst0", Z);
    nx(); exq("rst1", Z);
    nx(); rst = 1'b0; id_off(); exq("post_rst", Z);
    nx(); exq("redir", ov(0, 1, 1, 0, 0, 0, 0, 0));
    nx(); ex_redirect = 1'b0; exq("idle0", Z);
    nx(); exq("idle1", Z);

    // lw x5 ; add x6,x5,x1
    nx(); lw(5'd5, 5'd1); exq("lu_a1", Z);
    nx(); alu(5'd6, 5'd5, 1, 5'd1, 1);
    exq("lu_stall", ov(1, 1, 0, 0, 0, 0, 0, 0));
    nx(); exq("lu_after", ov(0, 0, 0, 0, 1, 0, 0, 0));
    nx(); id_off(); exq("lu_fwd_wb", ov(0, 0, 0, 0, 0, 0, 2, 0));
    nx(); exq("lu_drain", Z);

    // addi x3 ; sub x4,x3,x3 back-to-back
    nx(); alu(5'd3, 5'd1, 1, 0, 0); exq("b1", Z);
    nx(); alu(5'd4, 5'd3, 1, 5'd3, 1); exq("b2", Z);
    nx(); id_off(); exq("fwd_mem", ov(0, 0, 0, 0, 0, 0, 1, 1));
    // one instruction in between
    nx(); alu(5'd3, 5'd1, 1, 0, 0); exq("b4", Z);
    nx(); alu(5'd9, 5'd0, 1, 0, 0); exq("b5", Z);
    nx(); alu(5'd4, 5'd3, 1, 5'd3, 1); exq("b6_x0src", Z);
    nx(); id_off(); exq("fwd_wb", ov(0, 0, 0, 0, 0, 0, 2, 2));
    // rd = x0 producers
    nx(); alu(5'd0, 5'd1, 1, 0, 0); exq("b8", Z);
    nx(); alu(5'd7, 5'd0, 1, 5'd0, 1); exq("b9", Z);
    nx(); id_off(); exq("x0_nofwd", Z);
    nx(); lw(5'd0, 5'd0); exq("b11", Z);
    nx(); alu(5'd8, 5'd0, 1, 5'd0, 1); exq("x0_nostall", Z);
    nx(); id_off(); exq("b13", ov(0, 0, 0, 0, 1, 0, 0, 0));
    nx(); exq("b14", Z);

    // store as producer: no stall, no forward
    nx(); id_set(1, 5'd5, 0, 5'd2, 1, 5'd5, 1, 1, 1); exq("s1", Z);
    nx(); alu(5'd6, 5'd5, 1, 0, 0); exq("st_nostall", Z);
    nx(); id_off(); exq("st_nofwd", ov(0, 0, 0, 0, 1, 0, 0, 0));
    nx(); exq("s4", Z);

    // dmem wait of 3 cycles with a WB bypass held in place
    nx(); alu(5'd13, 5'd1, 1, 0, 0); exq("c1", Z);
    nx(); lw(5'd10, 5'd2); exq("c2", Z);
    nx(); alu(5'd14, 5'd13, 1, 0, 0); exq("c3", Z);
    nx(); id_off(); dmem_ready = 1'b0;
    exq("wait0", ov(1, 0, 0, 1, 1, 0, 2, 0));
    nx(); exq("wait1", ov(1, 0, 0, 1, 1, 0, 2, 0));
    nx(); exq("wait2", ov(1, 0, 0, 1, 1, 0, 2, 0));
    nx(); dmem_ready = 1'b1;
    exq("wait_done", ov(1, 1, 0, 0, 1, 0, 2, 0));
    nx(); exq("c8", Z);
    nx(); exq("c9", Z);

    // timeout: 16 frozen cycles then sticky mem_err
    nx(); lw(5'd15, 5'd2); exq("d1", Z);
    nx(); id_off(); exq("d2", Z);
    nx(); dmem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) nx();
      exq($sformatf("to_frz%0d", i), ov(1, 0, 0, 1, 1, 0, 0, 0));
    end
    nx(); exq("to_resume", ov(0, 0, 0, 0, 0, 1, 0, 0));
    nx(); dmem_ready = 1'b1; exq("to_sticky", ov(0, 0, 0, 0, 0, 1, 0, 0));

    // redirect outranks load-use
    nx(); lw(5'd5, 5'd2); exq("e1", ov(0, 0, 0, 0, 0, 1, 0, 0));
    nx(); alu(5'd6, 5'd5, 1, 0, 0); ex_redirect = 1'b1;
    exq("redir_vs_lu", ov(0, 1, 1, 0, 0, 1, 0, 0));
    nx(); ex_redirect = 1'b0; id_off();
    exq("e3", ov(0, 0, 0, 0, 1, 1, 0, 0));

    // reset during MEM_WAIT
    nx(); alu(5'd20, 5'd1, 1, 0, 0); exq("f1", ov(0, 0, 0, 0, 0, 1, 0, 0));
    nx(); lw(5'd21, 5'd2); exq("f2", ov(0, 0, 0, 0, 0, 1, 0, 0));
    nx(); id_off(); exq("f3", ov(0, 0, 0, 0, 0, 1, 0, 0));
    nx(); dmem_ready = 1'b0; exq("f4", ov(1, 0, 0, 1, 1, 1, 0, 0));
    nx(); rst = 1'b1; exq("rst_in_wait", Z);
    nx(); rst = 1'b0; alu(5'd22, 5'd21, 1, 5'd20, 1); exq("rst_after", Z);
    nx(); id_off(); exq("rst_nofwd", Z);
    nx(); dmem_ready = 1'b1; exq("f8", Z);

    nx();
    #6;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
